// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Forward-select codes, FSM states, register-match functions.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M-stage result wins over W-stage; r0 is hardwired and never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wm,
    input logic       rwm,
    input logic [4:0] ww,
    input logic       rww
  );
    if (src != 5'd0 && src == wm && rwm)
      return FWD_M;
    if (src != 5'd0 && src == ww && rww)
      return FWD_W;
    return FWD_RF;
  endfunction

  // true when a non-zero dest matches either decode source
  function automatic logic dst_hit(
    input logic [4:0] dst,
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (dst != 5'd0) && (dst == a || dst == b);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div in-flight down-counter.
// Loads on accepted issue, counts down every cycle, saturates at 0.
module md_busy_counter #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(MD_LATENCY - 1);

  // load has priority; otherwise tick down and hold at zero
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  // busy whenever a result is still pending
  always_comb begin
    busy = (cnt != '0);
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline.
// Forwarding and stalls are combinational; only FSM and md count are stateful.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MdStartE,
  input  logic       MdUseD,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushE,
  output logic       FlushW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MdBusy
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] md_cnt;
  logic             md_load;
  logic             memwait;
  logic             lwstall;
  logic             brstall;
  logic             mdstall;

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_cnt (
    .clock(clock),
    .reset(reset),
    .load (md_load),
    .cnt  (md_cnt),
    .busy (MdBusy)
  );

  // hazard terms; a new mult/div is only taken when E advances
  always_comb begin
    memwait = MemReqM & ~MemReadyM;
    lwstall = MemtoRegE & (RtE == RsD | RtE == RtD);
    brstall = BranchD &
      ((RegWriteE & dst_hit(WriteRegE, RsD, RtD)) |
       (MemtoRegM & dst_hit(WriteRegM, RsD, RtD)));
    mdstall = MdUseD & (state == MD_BUSY | MdStartE);
    md_load = MdStartE & ~memwait & (state != MD_BUSY);
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset)
      state <= RUN;
    else
      state <= state_nx;
  end

  // next state; the counter keeps running through memory waits
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (memwait)
          state_nx = MEM_WAIT;
        else if (md_load)
          state_nx = MD_BUSY;
      end
      MEM_WAIT: begin
        if (!memwait) begin
          if (md_load || md_cnt > CNT_W'(1))
            state_nx = MD_BUSY;
          else
            state_nx = RUN;
        end
      end
      MD_BUSY: begin
        if (memwait)
          state_nx = MEM_WAIT;
        else if (md_cnt <= CNT_W'(1))
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // stall/flush/forward outputs; freeze beats data stalls
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM,
                          WriteRegW, RegWriteW);
      ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM,
                          WriteRegW, RegWriteW);
      ForwardAD = (RsD != 5'd0) & (RsD == WriteRegM)
                & RegWriteM;
      ForwardBD = (RtD != 5'd0) & (RtD == WriteRegM)
                & RegWriteM;
      if (memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (lwstall | brstall | mdstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_hazard_controller;

  typedef struct packed {
    logic       sf;
    logic       sd;
    logic       se;
    logic       sm;
    logic       fe;
    logic       fw;
    logic       fad;
    logic       fbd;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       busy;
  } out_t;

  typedef struct {
    string name;
    out_t  exp;
  } item_t;

  logic       clock;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, BranchD;
  logic       MdStartE, MdUseD, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushE, FlushW, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MdBusy;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  logic  done  = 1'b0;
  out_t  act;
  out_t  e;

  hazard_controller #(
    .MD_LATENCY(12),
    .CNT_W     (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .RsD      (RsD),
    .RtD      (RtD),
    .RsE      (RsE),
    .RtE      (RtE),
    .WriteRegE(WriteRegE),
    .WriteRegM(WriteRegM),
    .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .MemtoRegM(MemtoRegM),
    .BranchD  (BranchD),
    .MdStartE (MdStartE),
    .MdUseD   (MdUseD),
    .MemReqM  (MemReqM),
    .MemReadyM(MemReadyM),
    .StallF   (StallF),
    .StallD   (StallD),
    .StallE   (StallE),
    .StallM   (StallM),
    .FlushE   (FlushE),
    .FlushW   (FlushW),
    .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .MdBusy   (MdBusy)
  );

  assign act = {StallF, StallD, StallE, StallM,
                FlushE, FlushW, ForwardAD, ForwardBD,
                ForwardAE, ForwardBE, MdBusy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t stl(input logic b);
    out_t o = '0;
    o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1; o.busy = b;
    return o;
  endfunction

  function automatic out_t frz(input logic b);
    out_t o = '0;
    o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.sm = 1'b1;
    o.fw = 1'b1; o.busy = b;
    return o;
  endfunction

  function automatic out_t rstv(input logic b);
    out_t o = '0;
    o.fe = 1'b1; o.fw = 1'b1; o.busy = b;
    return o;
  endfunction

  function automatic out_t bsy();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic clr();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MdStartE = 0; MdUseD = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic step(input string n, input out_t x);
    item_t it;
    it.name = n;
    it.exp  = x;
    q.push_back(it);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    item_t it;
    if (q.size() != 0) begin
      it = q.pop_front();
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %b want %b",
                 it.name, act, it.exp);
      end
    end else if (done) begin
      if (bad == 0 && total >= 12)
        $display("PASS");
      else
        $display("FAIL summary");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: no summary after 50000 time units");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clock);
    #1;
    step("rst0", rstv(1'b0));
    step("rst1", rstv(1'b0));
    reset = 1'b0;

    RsE = 5; WriteRegM = 5; RegWriteM = 1;
    WriteRegW = 5; RegWriteW = 1;
    e = '0; e.fae = 2'b10;
    step("fwd_ae_m", e);
    RsE = 0;
    step("fwd_ae_r0", '0);
    RsE = 7; RtE = 7; WriteRegM = 3; WriteRegW = 7;
    e = '0; e.fae = 2'b01; e.fbe = 2'b01;
    step("fwd_w", e);
    RsE = 0; RtE = 9; WriteRegM = 9; RegWriteM = 0;
    WriteRegW = 9;
    e = '0; e.fbe = 2'b01;
    step("fwd_be_w", e);

    clr();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step("lw_rs", stl(1'b0));
    RsD = 0; RtD = 8;
    step("lw_rt", stl(1'b0));
    MemtoRegE = 0;
    step("lw_gone", '0);

    clr();
    BranchD = 1; RsD = 3; WriteRegE = 3; RegWriteE = 1;
    step("br_e", stl(1'b0));
    WriteRegE = 4; WriteRegM = 3; RegWriteM = 1;
    e = '0; e.fad = 1'b1;
    step("br_fwd", e);
    clr();
    BranchD = 1; RtD = 6; WriteRegM = 6;
    RegWriteM = 1; MemtoRegM = 1;
    e = stl(1'b0); e.fbd = 1'b1;
    step("br_ld_m", e);
    clr();
    BranchD = 1; RegWriteE = 1;
    step("br_r0", '0);

    clr();
    MemReqM = 1;
    step("mw0", frz(1'b0));
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step("mw1_lw", frz(1'b0));
    MemtoRegE = 0; RtE = 0; RsD = 0;
    step("mw2", frz(1'b0));
    step("mw3", frz(1'b0));
    MemReadyM = 1;
    step("mw_rel", '0);
    clr();
    step("mw_run", '0);

    MdStartE = 1; MdUseD = 1;
    step("md_start", stl(1'b0));
    for (int k = 11; k >= 1; k--) begin
      MdStartE = (k == 5);
      step("md_busy", stl(1'b1));
    end
    MdStartE = 0;
    step("md_done", '0);
    if (MdBusy !== 1'b0) begin
      bad++;
      $display("FAIL md_done_busy: MdBusy=%b", MdBusy);
    end

    clr();
    MdStartE = 1;
    step("md2_start", '0);
    MdStartE = 0; MemReqM = 1;
    step("md2_mw11", frz(1'b1));
    step("md2_mw10", frz(1'b1));
    step("md2_mw9", frz(1'b1));
    MemReadyM = 1;
    step("md2_rel8", bsy());
    clr();
    MdUseD = 1;
    for (int k = 7; k >= 1; k--)
      step("md2_busy", stl(1'b1));
    step("md2_done", '0);
    if (MdBusy !== 1'b0) begin
      bad++;
      $display("FAIL md2_done_busy: MdBusy=%b", MdBusy);
    end

    clr();
    MdStartE = 1;
    step("rs_start", '0);
    MdStartE = 0;
    step("rs_c11", bsy());
    MemReqM = 1;
    step("rs_mw10", frz(1'b1));
    reset = 1;
    RsE = 5; WriteRegM = 5; RegWriteM = 1; RtD = 5;
    step("rs_hold", rstv(1'b1));
    if (MdBusy !== 1'b0) begin
      bad++;
      $display("FAIL rs_clr_busy: MdBusy=%b", MdBusy);
    end
    reset = 0;
    clr();
    MdUseD = 1;
    step("rs_after", '0);
    MemReqM = 1;
    step("rs_mw_new", frz(1'b0));
    clr();
    done = 1'b1;
  end

endmodule
